// File: rtl/audio_level_meter.sv
// audio_level_meter: per-channel bar level (instant attack, linear decay), peak hold marker and sticky clip flags
//   s_valid/s_ready/s_data/s_chan : signed sample stream, one channel tag per sample
//   frame_tick : closes the window and starts a one-channel-per-cycle update (busy while running)
//   clear : drops overload flags; rd_chan -> rd_level/rd_peak : registered read port
module audio_level_meter #(
  parameter int SAMPLE_W = 16,
  parameter int CHANNELS = 2,
  parameter int LEVEL_W = 8,
  parameter int DECAY_STEP = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [CH_W-1:0]     s_chan,
  input  logic                frame_tick,
  input  logic                clear,
  input  logic [CH_W-1:0]     rd_chan,
  output logic [LEVEL_W-1:0]  rd_level,
  output logic [LEVEL_W-1:0]  rd_peak,
  output logic [CHANNELS-1:0] overload,
  output logic                busy
);
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [LEVEL_W-1:0] DEC = LEVEL_W'(DECAY_STEP);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_FRAMES);
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] idx;
  logic pend, neg, clip, acc, in_rng, last;
  logic [LEVEL_W-1:0] window [CHANNELS];
  logic [LEVEL_W-1:0] level [CHANNELS];
  logic [LEVEL_W-1:0] peak [CHANNELS];
  logic [HW-1:0] hold [CHANNELS];
  logic [SAMPLE_W-1:0] full;
  logic [SAMPLE_W-2:0] mag;
  logic [LEVEL_W-1:0] scaled, w, l, p, l_dec, p_dec, l_n, p_n;
  logic [HW-1:0] h, h_n;
  logic [CHANNELS-1:0] set_mask;
  assign neg = s_data[SAMPLE_W-1];
  assign full = neg ? -s_data : s_data;
  // only the most negative input still has the sign bit set after negation
  assign mag = (neg && full[SAMPLE_W-1]) ? '1 : full[SAMPLE_W-2:0];
  assign scaled = mag[SAMPLE_W-2 -: LEVEL_W];
  assign clip = &mag;
  assign s_ready = state == IDLE && !reset;
  assign busy = state == UPDATE;
  assign acc = s_valid && s_ready;
  assign in_rng = int'(s_chan) < CHANNELS;
  assign last = int'(idx) == CHANNELS - 1;
  assign set_mask = CHANNELS'(acc && in_rng && clip) << s_chan;
  assign w = window[idx];
  assign l = level[idx];
  assign p = peak[idx];
  assign h = hold[idx];
  assign l_dec = l > DEC ? l - DEC : '0;
  assign p_dec = p > DEC ? p - DEC : '0;
  assign l_n = w >= l ? w : (w > l_dec ? w : l_dec);
  assign p_n = l_n >= p ? l_n : (h != '0 ? p : (l_n > p_dec ? l_n : p_dec));
  assign h_n = l_n >= p ? HOLD : (h != '0 ? h - HW'(1) : h);
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (frame_tick || pend) ? UPDATE : IDLE;
    else state_n = last ? IDLE : UPDATE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      pend <= 1'b0;
      overload <= '0;
      rd_level <= '0;
      rd_peak <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        window[c] <= '0;
        level[c] <= '0;
        peak[c] <= '0;
        hold[c] <= '0;
      end
    end else begin
      state <= state_n;
      idx <= (busy && !last) ? idx + CH_W'(1) : '0;
      // a tick arriving mid-update is remembered once and consumed by the next IDLE cycle
      pend <= busy && (pend || frame_tick);
      overload <= (clear ? '0 : overload) | set_mask;
      rd_level <= int'(rd_chan) < CHANNELS ? level[rd_chan] : '0;
      rd_peak <= int'(rd_chan) < CHANNELS ? peak[rd_chan] : '0;
      if (busy) begin
        level[idx] <= l_n;
        peak[idx] <= p_n;
        hold[idx] <= h_n;
        window[idx] <= '0;
      end else if (acc && in_rng && scaled > window[s_chan]) begin
        window[s_chan] <= scaled;
      end
    end
  end
endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: random + directed stimulus checked every cycle against a frame-level behavioural model
module tb_audio_level_meter;
  localparam int SW = 16, C = 3, LW = 8, DS = 4, HF = 3, CW = 2;
  logic clk = 0, reset = 1, s_valid = 0, frame_tick = 0, clear = 0;
  logic [SW-1:0] s_data = '0;
  logic [CW-1:0] s_chan = '0, rd_chan = '0;
  logic s_ready, busy;
  logic [LW-1:0] rd_level, rd_peak;
  logic [C-1:0] overload;
  int n_chk = 0, n_fail = 0;
  bit armed = 0, m_busy = 0, m_pend = 0;
  int m_phase = 0, m_ovl = 0, m_rdl = 0, m_rdp = 0;
  int m_win [C], m_lvl [C], m_pk [C], m_hold [C];

  always #5 clk = ~clk;

  audio_level_meter #(.SAMPLE_W(SW), .CHANNELS(C), .LEVEL_W(LW), .DECAY_STEP(DS), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .frame_tick(frame_tick), .clear(clear), .rd_chan(rd_chan), .rd_level(rd_level), .rd_peak(rd_peak),
    .overload(overload), .busy(busy));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction

  // model: a frame update walks channels 0..C-1 one per cycle after the tick; samples only land while idle
  always @(posedge clk) begin
    int k, v, mag, nl, setm;
    if (reset) begin
      armed = 1; m_busy = 0; m_pend = 0; m_phase = 0; m_ovl = 0; m_rdl = 0; m_rdp = 0;
      for (int c = 0; c < C; c++) begin
        m_win[c] = 0; m_lvl[c] = 0; m_pk[c] = 0; m_hold[c] = 0;
      end
    end else if (armed) begin
      m_rdl = int'(rd_chan) < C ? m_lvl[rd_chan] : 0;
      m_rdp = int'(rd_chan) < C ? m_pk[rd_chan] : 0;
      setm = 0;
      if (m_busy) begin
        k = m_phase;
        nl = m_win[k] >= m_lvl[k] ? m_win[k] : imax(m_win[k], imax(m_lvl[k] - DS, 0));
        if (nl >= m_pk[k]) begin
          m_pk[k] = nl; m_hold[k] = HF;
        end else if (m_hold[k] > 0) m_hold[k]--;
        else m_pk[k] = imax(nl, imax(m_pk[k] - DS, 0));
        m_lvl[k] = nl;
        m_win[k] = 0;
        if (frame_tick) m_pend = 1;
        m_phase++;
        if (m_phase == C) m_busy = 0;
      end else begin
        if (s_valid && int'(s_chan) < C) begin
          v = $signed(s_data);
          mag = v < 0 ? -v : v;
          if (mag > 2 ** (SW - 1) - 1) mag = 2 ** (SW - 1) - 1;
          m_win[s_chan] = imax(m_win[s_chan], mag >> (SW - 1 - LW));
          if (mag == 2 ** (SW - 1) - 1) setm = 1 << s_chan;
        end
        if (frame_tick || m_pend) begin
          m_busy = 1; m_phase = 0; m_pend = 0;
        end
      end
      m_ovl = (clear ? 0 : m_ovl) | setm;
    end
  end

  always @(negedge clk) if (armed) begin
    check("s_ready", s_ready, 32'(!reset && !m_busy));
    check("busy", busy, 32'(m_busy));
    check("overload", overload, m_ovl);
    check("rd_level", rd_level, m_rdl);
    check("rd_peak", rd_peak, m_rdp);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int d);
    s_valid = 1; s_chan = ch[CW-1:0]; s_data = d[SW-1:0];
    step();
    s_valid = 0;
  endtask

  task automatic tick_wait();
    frame_tick = 1;
    step();
    frame_tick = 0;
    repeat (C) step();
  endtask

  task automatic rd(input int ch, output int lv, output int pk);
    rd_chan = ch[CW-1:0];
    step();
    lv = rd_level; pk = rd_peak;
  endtask

  initial begin
    int lv, pk, cnt;
    repeat (3) step();
    check("reset_s_ready", s_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_level", rd_level, 0);
    check("reset_overload", overload, 0);
    reset = 0;
    #1;
    check("ready_after_reset", s_ready, 1);
    step();
    send(0, 'h4000);
    tick_wait();
    rd(0, lv, pk);
    check("attack_level", lv, 128);
    check("attack_peak", pk, 128);
    rd(1, lv, pk);
    check("ch1_level", lv, 0);
    check("ch1_peak", pk, 0);
    for (int i = 1; i <= 12; i++) begin
      tick_wait();
      rd(0, lv, pk);
      check("decay_level", lv, 128 - 4 * i);
      check("decay_peak", pk, i <= 3 ? 128 : 128 - 4 * (i - 3));
    end
    send(1, -32768);
    check("ovl_set", overload, 3'b010);
    tick_wait();
    rd(1, lv, pk);
    check("sat_level", lv, 255);
    clear = 1;
    step();
    clear = 0;
    check("ovl_clear", overload, 0);
    frame_tick = 1;
    step();
    frame_tick = 0;
    s_valid = 1; s_chan = 2; s_data = 16'h2000; cnt = 0;
    while (!s_ready && cnt < 10) begin
      cnt++;
      step();
    end
    check("backpressure_cycles", cnt, C);
    step();
    s_valid = 0;
    tick_wait();
    rd(2, lv, pk);
    check("held_sample_level", lv, 64);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      frame_tick = (i == 0 || i == 2 || i == 3);
      step();
      cnt += busy;
      if (i == 3) check("gap_idle", busy, 0);
    end
    frame_tick = 0;
    check("double_update_busy", cnt, 2 * C);
    send(0, 'h7fff);
    tick_wait();
    rd(0, lv, pk);
    check("pre_reset_level", lv, 255);
    frame_tick = 1;
    step();
    frame_tick = 0;
    step();
    reset = 1;
    step();
    check("midreset_busy", busy, 0);
    check("midreset_ready", s_ready, 0);
    check("midreset_level", rd_level, 0);
    check("midreset_peak", rd_peak, 0);
    check("midreset_overload", overload, 0);
    reset = 0;
    step();
    check("oor_ready", s_ready, 1);
    send(3, 'h7fff);
    check("oor_overload", overload, 0);
    tick_wait();
    for (int c = 0; c < C; c++) begin
      rd(c, lv, pk);
      check("oor_level", lv, 0);
    end
    rd(3, lv, pk);
    check("oor_rd_level", lv, 0);
    for (int i = 0; i < 3000; i++) begin
      s_valid = ((i / 400) % 2 == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      s_chan = CW'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: s_data = 16'h8000;
        1: s_data = 16'h7fff;
        default: s_data = SW'($urandom);
      endcase
      frame_tick = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 400) == 0);
      rd_chan = CW'($urandom_range(0, 3));
      step();
    end
    s_valid = 0; frame_tick = 0; clear = 0; reset = 0;
    repeat (2 * C + 2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
